enemy_mover: RTL and testbench
==============================

// Module: enemy_mover
// PURPOSE
// Parametrised enemy-movement engine. On each start it checks its move timer. If the timer has
// expired, it scans the whole level grid and moves every enemy at most one cell, in random or
// chase mode, retrying blocked directions. A fix-up pass then restores moved-enemy tags.
// It sits between the game-tick controller and the level grid RAM, with combinational read.
// PARAMETERS
// GRID_W       40      grid columns; x in 0..GRID_W-1
// GRID_H       30      grid rows; y in 0..GRID_H-1
// X_BITS       6       width of x coordinate
// Y_BITS       5       width of y coordinate
// CELL_BITS    3       width of a grid cell code
// AIR_CODE     0       code of an empty (walkable) cell
// ENEMY_CODE   4       code of an enemy cell
// MOVED_CODE   5       temporary tag for an enemy already moved this pass; must differ from all other codes
// MOVE_PERIOD  200000  cycles between move passes (>=2)
// LFSR_SEED    8'hA5   non-zero seed of the 8-bit direction LFSR
// PORTS
// clock       in   1          system clock
// reset       in   1          synchronous, active-high
// start       in   1          request one update; ignored unless in IDLE
// mode        in   1          0 = random walk, 1 = chase target; sampled on start
// target_x    in   X_BITS     chase target x (player); sampled on start
// target_y    in   Y_BITS     chase target y; sampled on start
// done        out  1          one-cycle pulse when the request finishes
// busy        out  1          high from the cycle after start until done
// moved_count out  X_BITS+Y_BITS  enemies moved in the last pass; held until the next pass
// grid_x      out  X_BITS     grid address x
// grid_y      out  Y_BITS     grid address y
// grid_out    in   CELL_BITS  cell at (grid_x,grid_y), same-cycle combinational read
// grid_write  out  1          write strobe; writes grid_in at the clock edge
// grid_in     out  CELL_BITS  write data
// BEHAVIOUR
// - Reset: state IDLE; done=0, busy=0, grid_write=0, grid_x=0, grid_y=0, grid_in=AIR_CODE,
//   moved_count=0; timer=MOVE_PERIOD-1; lfsr=LFSR_SEED. A mid-pass reset abandons the pass.
//   MOVED_CODE cells already written are left in the grid.
// - Timer: decrements every cycle while non-zero, saturates at 0, and reloads MOVE_PERIOD-1 in INIT.
// - LFSR: x^8+x^6+x^5+x^4+1, advances every cycle, including IDLE.
// - FSM states: IDLE -start-> ARM. ARM: timer!=0 -> DONE (no grid writes, moved_count kept),
//   else -> INIT.
//   INIT: cursor=(0,0), moved_count=0, timer reload -> READ.
//   READ: address=cursor; grid_out==ENEMY_CODE -> PICK, else -> NEXT.
//   PICK: set dir0 and tries=0 -> PROBE.
//   PROBE: address=candidate; if candidate is in bounds and grid_out==AIR_CODE -> WRITE_NEW;
//   else if tries==3 -> NEXT; else dir=(dir+1) mod 4 and tries++ -> PROBE.
//   WRITE_NEW: write MOVED_CODE at candidate -> ERASE. ERASE: write AIR_CODE at cursor,
//   moved_count++ -> NEXT.
//   NEXT: if cursor=(GRID_W-1,GRID_H-1) -> FIX_INIT, else advance cursor x-major -> READ.
//   FIX_INIT: cursor=(0,0) -> FIX_READ.
//   FIX_READ: grid_out==MOVED_CODE -> FIX_WRITE (write ENEMY_CODE) -> FIX_NEXT; else -> FIX_NEXT.
//   FIX_NEXT: last cell -> DONE, else advance -> FIX_READ.
//   DONE: done=1 -> IDLE.
// - Directions: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).
//   Out of bounds means x-1 at x=0, y-1 at y=0, x+1 at GRID_W-1, or y+1 at GRID_H-1. An out-of-bounds
//   candidate counts as blocked; no grid access wraps around.
// - dir0 in random mode is lfsr[1:0].
// - dir0 in chase mode: compare |dx|=|tx-x| with |dy|=|ty-y|. If |dx|>=|dy| and dx!=0, use right
//   or left; else if dy!=0, use down or up. If the enemy is on the target, it does not move
//   (-> NEXT with no probe).
// - MOVED_CODE cells are never treated as enemies in the scan, so no enemy moves twice per pass.
// - grid_write=1 only in WRITE_NEW, ERASE and FIX_WRITE. grid_in=AIR_CODE when not writing.
// - busy=1 in every state except IDLE.
// - The done pulse is also produced for a skipped (timer-not-expired) request, 2 cycles after start.
// - moved_count saturates at its maximum value.
// TESTING
// 1. After reset, pulse start at cycle 5 (timer!=0) -> done 2 cycles later, grid_write never 1,
//    moved_count=0.
// 2. MOVE_PERIOD=4, 4x4 grid, enemy at (1,1), all other cells air, mode=1, target=(3,1)
//    -> (2,1)=ENEMY_CODE, (1,1)=AIR_CODE, moved_count=1.
// 3. Enemy at (0,0) walled in at (1,0) and (0,1), random mode -> 4 probes, no writes,
//    cell unchanged, moved_count=0.
// 4. Enemies at (0,0) and (1,0) in a row of air, chase target (3,0) -> (0,0) is blocked
//    and does not move; (1,0) moves to (2,0) exactly once; no MOVED_CODE remains
//    after done; moved_count=1.
// 5. Assert reset during WRITE_NEW -> next cycle all outputs at reset values, state IDLE;
//    the next start with an expired timer completes normally.
// 6. Random mode over 100 passes on an open 8x8 grid -> enemy count constant;
//    all 4 directions observed.

Source files
------------

// File: rtl/enemy_mover.sv
// Enemy movement engine: on an expired move timer it scans the level grid, steps each enemy
// one cell (random walk or chase), then a fix-up scan turns MOVED tags back into enemies.
module enemy_mover #(
  parameter int         GRID_W      = 40,
  parameter int         GRID_H      = 30,
  parameter int         X_BITS      = 6,
  parameter int         Y_BITS      = 5,
  parameter int         CELL_BITS   = 3,
  parameter int         AIR_CODE    = 0,
  parameter int         ENEMY_CODE  = 4,
  parameter int         MOVED_CODE  = 5,
  parameter int         MOVE_PERIOD = 200000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [X_BITS-1:0]          target_x,
  input  logic [Y_BITS-1:0]          target_y,
  output logic                       done,
  output logic                       busy,
  output logic [X_BITS+Y_BITS-1:0]   moved_count,
  output logic [X_BITS-1:0]          grid_x,
  output logic [Y_BITS-1:0]          grid_y,
  input  logic [CELL_BITS-1:0]       grid_out,
  output logic                       grid_write,
  output logic [CELL_BITS-1:0]       grid_in
);

  localparam int TIMER_W = $clog2(MOVE_PERIOD);
  localparam int CW      = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int MC_W    = X_BITS + Y_BITS;
  localparam logic [TIMER_W-1:0]   T_RELOAD = TIMER_W'(MOVE_PERIOD - 1);
  localparam logic [X_BITS-1:0]    X_LAST   = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0]    Y_LAST   = Y_BITS'(GRID_H - 1);
  localparam logic [CELL_BITS-1:0] AIR      = CELL_BITS'(AIR_CODE);
  localparam logic [CELL_BITS-1:0] ENEMY    = CELL_BITS'(ENEMY_CODE);
  localparam logic [CELL_BITS-1:0] MOVED    = CELL_BITS'(MOVED_CODE);

  typedef enum logic [3:0] {
    IDLE, ARM, INIT, READ, PICK, PROBE, WRITE_NEW, ERASE, NEXT,
    FIX_INIT, FIX_READ, FIX_WRITE, FIX_NEXT, DONE
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic [7:0]          lfsr;
  logic [X_BITS-1:0]   cur_x, tx_q, nxt_x, paddr_x;
  logic [Y_BITS-1:0]   cur_y, ty_q, nxt_y, paddr_y;
  logic [1:0]          dir, tries, chase_dir, dir0, pdir;
  logic                mode_q, chase_hold, last_cell;
  logic [CW-1:0]       adx, ady;

  // Directions: 0 up, 1 right, 2 down, 3 left; a step off the grid edge is blocked.
  function automatic logic cand_ok(input logic [1:0] d, input logic [X_BITS-1:0] x,
                                   input logic [Y_BITS-1:0] y);
    case (d)
      2'd0:    return y != '0;
      2'd1:    return x != X_LAST;
      2'd2:    return y != Y_LAST;
      default: return x != '0;
    endcase
  endfunction

  function automatic logic [X_BITS-1:0] cand_x(input logic [1:0] d, input logic [X_BITS-1:0] x);
    return (d == 2'd1) ? x + X_BITS'(1) : (d == 2'd3) ? x - X_BITS'(1) : x;
  endfunction

  function automatic logic [Y_BITS-1:0] cand_y(input logic [1:0] d, input logic [Y_BITS-1:0] y);
    return (d == 2'd2) ? y + Y_BITS'(1) : (d == 2'd0) ? y - Y_BITS'(1) : y;
  endfunction

  always_comb begin
    adx = CW'((tx_q >= cur_x) ? tx_q - cur_x : cur_x - tx_q);
    ady = CW'((ty_q >= cur_y) ? ty_q - cur_y : cur_y - ty_q);
    chase_hold = (adx == '0) && (ady == '0);
    if (adx >= ady && adx != '0) chase_dir = (tx_q > cur_x) ? 2'd1 : 2'd3;
    else                         chase_dir = (ty_q > cur_y) ? 2'd2 : 2'd0;
    dir0 = mode_q ? chase_dir : lfsr[1:0];
    // Address for the next probe: the first direction out of PICK, the next one on a retry.
    pdir = (state == PICK) ? dir0 : dir + 2'd1;
    paddr_x = cand_ok(pdir, cur_x, cur_y) ? cand_x(pdir, cur_x) : cur_x;
    paddr_y = cand_ok(pdir, cur_x, cur_y) ? cand_y(pdir, cur_y) : cur_y;
    last_cell = (cur_x == X_LAST) && (cur_y == Y_LAST);
    nxt_x = (cur_x == X_LAST) ? '0 : cur_x + X_BITS'(1);
    nxt_y = (cur_x == X_LAST) ? cur_y + Y_BITS'(1) : cur_y;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      busy        <= 1'b0;
      grid_write  <= 1'b0;
      grid_x      <= '0;
      grid_y      <= '0;
      grid_in     <= AIR;
      moved_count <= '0;
      timer       <= T_RELOAD;
      lfsr        <= LFSR_SEED;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (timer != '0) timer <= timer - TIMER_W'(1);
      done       <= 1'b0;
      grid_write <= 1'b0;
      grid_in    <= AIR;
      case (state)
        IDLE: if (start) begin
          state  <= ARM;
          busy   <= 1'b1;
          mode_q <= mode;
          tx_q   <= target_x;
          ty_q   <= target_y;
        end
        ARM: if (timer != '0) begin
          state <= DONE;
          done  <= 1'b1;
        end else state <= INIT;
        INIT: begin
          cur_x       <= '0;
          cur_y       <= '0;
          grid_x      <= '0;
          grid_y      <= '0;
          moved_count <= '0;
          timer       <= T_RELOAD;
          state       <= READ;
        end
        READ: state <= (grid_out == ENEMY) ? PICK : NEXT;
        PICK: if (mode_q && chase_hold) state <= NEXT;
        else begin
          dir    <= dir0;
          tries  <= 2'd0;
          grid_x <= paddr_x;
          grid_y <= paddr_y;
          state  <= PROBE;
        end
        PROBE: if (cand_ok(dir, cur_x, cur_y) && grid_out == AIR) begin
          grid_write <= 1'b1;
          grid_in    <= MOVED;
          state      <= WRITE_NEW;
        end else if (tries == 2'd3) state <= NEXT;
        else begin
          dir    <= dir + 2'd1;
          tries  <= tries + 2'd1;
          grid_x <= paddr_x;
          grid_y <= paddr_y;
        end
        WRITE_NEW: begin
          grid_x     <= cur_x;
          grid_y     <= cur_y;
          grid_write <= 1'b1;
          state      <= ERASE;
        end
        ERASE: begin
          if (moved_count != '1) moved_count <= moved_count + MC_W'(1);
          state <= NEXT;
        end
        NEXT: if (last_cell) state <= FIX_INIT;
        else begin
          cur_x  <= nxt_x;
          cur_y  <= nxt_y;
          grid_x <= nxt_x;
          grid_y <= nxt_y;
          state  <= READ;
        end
        FIX_INIT: begin
          cur_x  <= '0;
          cur_y  <= '0;
          grid_x <= '0;
          grid_y <= '0;
          state  <= FIX_READ;
        end
        FIX_READ: if (grid_out == MOVED) begin
          grid_write <= 1'b1;
          grid_in    <= ENEMY;
          state      <= FIX_WRITE;
        end else state <= FIX_NEXT;
        FIX_WRITE: state <= FIX_NEXT;
        FIX_NEXT: if (last_cell) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          cur_x  <= nxt_x;
          cur_y  <= nxt_y;
          grid_x <= nxt_x;
          grid_y <= nxt_y;
          state  <= FIX_READ;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_mover.sv
// Bench for enemy_mover on an 8x8 grid: directed scenarios plus randomized passes checked
// against a scan-order model of the movement rules and a cycle-count model of the move timer.
module tb_enemy_mover;
  localparam int GW = 8, GH = 8, P = 40;
  localparam logic [2:0] AIR = 3'd0, WALL = 3'd1, ENEMY = 3'd4, MOVED = 3'd5;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic [5:0]  target_x = '0, grid_x;
  logic [4:0]  target_y = '0, grid_y;
  logic        done, busy, grid_write;
  logic [10:0] moved_count;
  logic [2:0]  grid_out, grid_in;

  logic [2:0]  ram [GH][GW];
  logic [2:0]  init_grid [GH][GW];
  logic [2:0]  mg [GH][GW];
  logic        load = 1'b0;
  logic [13:0] wlog [$];

  int checks = 0, errors = 0;
  int cyc = 0, rl = 0, skip_done_edge = 0;
  logic mbusy = 1'b0, exp_skip = 1'b0, armed = 1'b0;
  logic [3:0] seen = '0;

  enemy_mover #(.GRID_W(GW), .GRID_H(GH), .MOVE_PERIOD(P)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .target_x(target_x), .target_y(target_y), .done(done), .busy(busy),
    .moved_count(moved_count), .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
    .grid_write(grid_write), .grid_in(grid_in));

  always #5 clock = ~clock;

  assign grid_out = (grid_x < 6'd8 && grid_y < 5'd8) ? ram[grid_y[2:0]][grid_x[2:0]] : 3'd7;

  always @(posedge clock) begin
    if (load) ram <= init_grid;
    else if (grid_write && grid_x < 6'd8 && grid_y < 5'd8) ram[grid_y[2:0]][grid_x[2:0]] <= grid_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Timer model: edges since the last reload; reload at reset and two edges after an accepted start.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      rl <= cyc + 1;
      mbusy <= 1'b0;
      exp_skip <= 1'b0;
    end else if (start && !mbusy) begin
      mbusy <= 1'b1;
      if (cyc + 1 - rl >= P - 1) begin
        rl <= cyc + 3;
        exp_skip <= 1'b0;
      end else begin
        exp_skip <= 1'b1;
        skip_done_edge <= cyc + 2;
      end
    end else if (mbusy && done) mbusy <= 1'b0;
  end

  always @(negedge clock) begin
    if (grid_write) wlog.push_back({grid_x, grid_y, grid_in});
    if (armed) begin
      chk("busy", busy, mbusy);
      if (!grid_write) chk("grid_in_idle", grid_in, AIR);
      chk("addr_in_grid", grid_x < 6'd8 && grid_y < 5'd8, 1);
      if (!mbusy) begin
        chk("idle_done", done, 0);
        chk("idle_write", grid_write, 0);
      end else if (exp_skip) begin
        chk("skip_done_time", done, cyc == skip_done_edge);
        chk("skip_write", grid_write, 0);
      end
    end
  end

  function automatic logic [13:0] mk(input int x, input int y, input logic [2:0] d);
    return {6'(x), 5'(y), d};
  endfunction

  function automatic logic [13:0] lg(input int i);
    if (i < wlog.size()) return wlog[i];
    return '1;
  endfunction

  function automatic int ddx(input int d); return (d == 1) ? 1 : (d == 3) ? -1 : 0; endfunction
  function automatic int ddy(input int d); return (d == 2) ? 1 : (d == 0) ? -1 : 0; endfunction

  function automatic bit is_free(input int x, input int y, input int d);
    int nx, ny;
    nx = x + ddx(d);
    ny = y + ddy(d);
    if (nx < 0 || ny < 0 || nx >= GW || ny >= GH) return 1'b0;
    return mg[ny][nx] == AIR;
  endfunction

  function automatic int enemies();
    int n = 0;
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) if (ram[y][x] == ENEMY) n++;
    return n;
  endfunction

  task automatic check_pass(input bit md, input int tx, input int ty);
    int idx = 0, cnt = 0, bad = 0;
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) if (mg[y][x] == ENEMY) begin
      int d0 = 0, got = -1, dx, dy;
      if (md) begin
        dx = tx - x;
        dy = ty - y;
        if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy) && dx != 0) d0 = (dx > 0) ? 1 : 3;
        else if (dy != 0) d0 = (dy > 0) ? 2 : 0;
        else d0 = -1;
        if (d0 >= 0) for (int k = 0; k < 4; k++)
          if (got < 0 && is_free(x, y, (d0 + k) % 4)) got = (d0 + k) % 4;
      end else begin
        bit any = 1'b0;
        for (int k = 0; k < 4; k++) if (is_free(x, y, k)) begin
          any = 1'b1;
          if (lg(idx) == mk(x + ddx(k), y + ddy(k), MOVED)) got = k;
        end
        if (any) begin
          chk("random_step_to_free_neighbour", got >= 0, 1);
          if (got < 0) return;
          seen[got] = 1'b1;
        end
      end
      if (got >= 0) begin
        chk("move_write_new", lg(idx), mk(x + ddx(got), y + ddy(got), MOVED));
        chk("move_erase", lg(idx + 1), mk(x, y, AIR));
        mg[y + ddy(got)][x + ddx(got)] = MOVED;
        mg[y][x] = AIR;
        idx += 2;
        cnt++;
      end
    end
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) if (mg[y][x] == MOVED) begin
      chk("fixup_write", lg(idx), mk(x, y, ENEMY));
      mg[y][x] = ENEMY;
      idx++;
    end
    chk("write_count", wlog.size(), idx);
    chk("moved_count", moved_count, cnt);
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) if (ram[y][x] != mg[y][x]) bad++;
    chk("grid_after_pass", bad, 0);
  endtask

  task automatic run_req(input bit md, input int tx, input int ty, output int lat);
    logic [10:0] prev;
    mg = ram;
    prev = moved_count;
    wlog.delete();
    start = 1'b1;
    mode = md;
    target_x = 6'(tx);
    target_y = 5'(ty);
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 3000) begin
      @(negedge clock);
      lat++;
    end
    chk("done_seen", done, 1);
    if (!done) return;
    @(negedge clock);
    if (exp_skip) begin
      chk("skip_no_writes", wlog.size(), 0);
      chk("skip_keeps_count", moved_count, prev);
    end else check_pass(md, tx, ty);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_grid();
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    @(negedge clock);
  endtask

  task automatic clear_init();
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) init_grid[y][x] = AIR;
  endtask

  task automatic random_init();
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) begin
      int r = $urandom_range(0, 9);
      init_grid[y][x] = (r < 6) ? AIR : (r < 8) ? ENEMY : WALL;
    end
  endtask

  initial begin
    int lat, n0;
    bit found;
    clear_init();
    @(negedge clock);
    do_reset();
    armed = 1'b1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write", grid_write, 0);
    chk("rst_gx", grid_x, 0);
    chk("rst_gy", grid_y, 0);
    chk("rst_grid_in", grid_in, AIR);
    chk("rst_count", moved_count, 0);

    // Start shortly after reset: timer still running, request is skipped.
    run_req(1'b0, 0, 0, lat);
    chk("t1_model_skip", exp_skip, 1);
    chk("t1_done_two_cycles", lat, 1);
    chk("t1_no_writes", wlog.size(), 0);
    chk("t1_count", moved_count, 0);
    repeat (50) @(negedge clock);

    clear_init();
    init_grid[1][1] = ENEMY;
    load_grid();
    run_req(1'b1, 3, 1, lat);
    chk("t2_new_cell", ram[1][2], ENEMY);
    chk("t2_old_cell", ram[1][1], AIR);
    chk("t2_count", moved_count, 1);

    clear_init();
    init_grid[0][0] = ENEMY;
    init_grid[0][1] = WALL;
    init_grid[1][0] = WALL;
    load_grid();
    run_req(1'b0, 0, 0, lat);
    chk("t3_cell", ram[0][0], ENEMY);
    chk("t3_no_writes", wlog.size(), 0);
    chk("t3_count", moved_count, 0);

    clear_init();
    init_grid[0][0] = ENEMY;
    init_grid[0][1] = ENEMY;
    init_grid[1][0] = WALL;
    init_grid[1][1] = WALL;
    load_grid();
    run_req(1'b1, 3, 0, lat);
    chk("t4_blocked_stays", ram[0][0], ENEMY);
    chk("t4_vacated", ram[0][1], AIR);
    chk("t4_moved_once", ram[0][2], ENEMY);
    chk("t4_not_twice", ram[0][3], AIR);
    chk("t4_count", moved_count, 1);

    // Reset in the middle of a pass, right when the MOVED tag is being written.
    clear_init();
    init_grid[3][3] = ENEMY;
    load_grid();
    wlog.delete();
    start = 1'b1;
    mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clock);
      if (grid_write && grid_in == MOVED) found = 1'b1;
    end
    chk("t5_reached_write_new", found, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_write", grid_write, 0);
    chk("t5_gx", grid_x, 0);
    chk("t5_gy", grid_y, 0);
    chk("t5_grid_in", grid_in, AIR);
    chk("t5_count", moved_count, 0);
    reset = 1'b0;
    repeat (45) @(negedge clock);
    load_grid();
    run_req(1'b0, 0, 0, lat);
    chk("t5_model_pass", exp_skip, 0);
    chk("t5_count_after", moved_count, 1);

    // Random walk on an open grid: enemy population never changes.
    clear_init();
    for (int i = 0; i < 10; i++) init_grid[$urandom_range(0, 7)][$urandom_range(0, 7)] = ENEMY;
    load_grid();
    n0 = enemies();
    seen = '0;
    for (int p = 0; p < 100; p++) begin
      run_req(1'b0, 0, 0, lat);
      chk("t6_enemy_count", enemies(), n0);
    end
    chk("t6_all_dirs", seen, 4'hF);

    // Mixed modes on cluttered grids, with resets at random distances before the request.
    for (int p = 0; p < 30; p++) begin
      random_init();
      load_grid();
      if ($urandom_range(0, 3) == 0) begin
        do_reset();
        repeat ($urandom_range(0, 60)) @(negedge clock);
      end
      n0 = enemies();
      run_req(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7), lat);
      chk("mix_enemy_count", enemies(), n0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
